// File: rtl/divider_scheduler.sv
// Round-robin scheduler sharing one multi-cycle Divider among NUM_REQ requesters.
// Optional build macro DIV_ZERO_CHECK_EN answers divide-by-zero locally without starting the Divider.
//
// state | meaning
// IDLE  | waiting for a request; req_ready follows the round-robin grant
// BUSY  | operands held on div_*; first cycle pulses div_start, then count runs down
// RESP  | one-cycle rsp_valid pulse to the granted requester; rr_ptr advances
module divider_scheduler #(
    parameter int WORD_LENGTH = 16,
    parameter int NUM_REQ     = 4,
    parameter int DIV_LATENCY = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] req_dividend,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] req_divisor,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [WORD_LENGTH-1:0]         rsp_result,
    output logic [WORD_LENGTH-1:0]         rsp_remainder,
    output logic                           rsp_sign,
    output logic                           rsp_err,
    output logic [WORD_LENGTH-1:0]         div_dividend,
    output logic [WORD_LENGTH-1:0]         div_divisor,
    output logic                           div_start,
    input  logic [WORD_LENGTH-1:0]         div_result,
    input  logic [WORD_LENGTH-1:0]         div_remainder,
    input  logic                           div_sign
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
    localparam logic [CW-1:0] COUNT_LOAD = CW'(DIV_LATENCY - 1);
    localparam logic [PW-1:0] LAST_REQ   = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          grant_reg;
    logic [CW-1:0]          count;

    logic                   grant_any;
    logic [PW-1:0]          grant_idx;
    logic [NUM_REQ-1:0]     grant_onehot;
    logic [NUM_REQ-1:0]     grant_reg_onehot;
    logic [WORD_LENGTH-1:0] sel_dividend;
    logic [WORD_LENGTH-1:0] sel_divisor;
    logic                   sel_zero;

    // Walk downward so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        int            idx;
        logic [PW-1:0] idx_p;
        idx       = 0;
        idx_p     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_p = PW'(idx);
            if (req_valid[idx_p]) begin
                grant_any = 1'b1;
                grant_idx = idx_p;
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        if (grant_any) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        grant_reg_onehot            = '0;
        grant_reg_onehot[grant_reg] = 1'b1;
    end

    assign sel_dividend = req_dividend[int'(grant_idx)*WORD_LENGTH +: WORD_LENGTH];
    assign sel_divisor  = req_divisor[int'(grant_idx)*WORD_LENGTH +: WORD_LENGTH];

`ifdef DIV_ZERO_CHECK_EN
    assign sel_zero = (sel_divisor == '0);
`else
    assign sel_zero = 1'b0;
`endif

    // Gated by reset so every output reads 0 while reset is held.
    assign req_ready = (state == IDLE && !reset) ? grant_onehot : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant_reg     <= '0;
            count         <= '0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            div_start     <= 1'b0;
            rsp_valid     <= '0;
            rsp_result    <= '0;
            rsp_remainder <= '0;
            rsp_sign      <= 1'b0;
            rsp_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        grant_reg    <= grant_idx;
                        if (sel_zero) begin
                            rsp_valid     <= grant_onehot;
                            rsp_result    <= '1;
                            rsp_remainder <= sel_dividend;
                            rsp_sign      <= 1'b0;
                            rsp_err       <= 1'b1;
                            state         <= RESP;
                        end else begin
                            div_start <= 1'b1;
                            state     <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // The div_start cycle loads the counter, so count==0 lands DIV_LATENCY cycles after it.
                    if (div_start) begin
                        div_start <= 1'b0;
                        count     <= COUNT_LOAD;
                    end else if (count == '0) begin
                        rsp_valid     <= grant_reg_onehot;
                        rsp_result    <= div_result;
                        rsp_remainder <= div_remainder;
                        rsp_sign      <= div_sign;
                        rsp_err       <= 1'b0;
                        state         <= RESP;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
                    rr_ptr    <= (grant_reg == LAST_REQ) ? '0 : grant_reg + 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_scheduler.sv
// Bench for divider_scheduler: behavioural Divider, queued requesters, and a
// cycle-level model of grant order, latency and response data.
module tb_divider_scheduler;

    localparam int W = 16;
    localparam int N = 4;
    localparam int L = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_dividend;
    logic [N*W-1:0] req_divisor;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_result;
    logic [W-1:0]   rsp_remainder;
    logic           rsp_sign;
    logic           rsp_err;
    logic [W-1:0]   div_dividend;
    logic [W-1:0]   div_divisor;
    logic           div_start;
    logic [W-1:0]   div_result;
    logic [W-1:0]   div_remainder;
    logic           div_sign;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cnt = 0;

    logic [W-1:0] qa [N][$];
    logic [W-1:0] qb [N][$];
    int           log_q [$];

    bit           m_pend = 1'b0;
    bit           m_zero = 1'b0;
    int           m_idx = 0;
    int           m_start = 0;
    int           m_rsp = 0;
    int           m_free = 0;
    int           m_rr = 0;
    logic [W-1:0] m_a, m_b, m_q, m_r;
    logic         m_s, m_e;

    divider_scheduler #(
        .WORD_LENGTH(W),
        .NUM_REQ    (N),
        .DIV_LATENCY(L)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_result   (rsp_result),
        .rsp_remainder(rsp_remainder),
        .rsp_sign     (rsp_sign),
        .rsp_err      (rsp_err),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_start    (div_start),
        .div_result   (div_result),
        .div_remainder(div_remainder),
        .div_sign     (div_sign)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sign-magnitude divide: quotient/remainder of magnitudes, sign = xor of operand signs.
    function automatic void golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic [W-1:0] r,
                                   output logic s);
        int sa, sb, ua, ub;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = (sa < 0) ? -sa : sa;
        ub = (sb < 0) ? -sb : sb;
        if (ub == 0) begin
            q = '1;
            r = W'(ua);
            s = 1'b0;
        end else begin
            q = W'(ua / ub);
            r = W'(ua % ub);
            s = a[W-1] ^ b[W-1];
        end
    endfunction

    task automatic push_op(input int i, input int a, input int b);
        qa[i].push_back(W'(a));
        qb[i].push_back(W'(b));
    endtask

    function automatic bit queues_busy();
        for (int i = 0; i < N; i++) begin
            if (qa[i].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drain(input int max);
        int n;
        n = 0;
        while (n < max && (queues_busy() || req_valid != '0 || m_pend)) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: waited %0d cycles, limit %0d", n, max);
        end
        repeat (2) @(negedge clk);
    endtask

    // Requesters: hold the head of each queue until the handshake completes.
    initial begin
        logic [N-1:0] hs;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        forever begin
            @(posedge clk);
            hs = req_valid & req_ready & {N{~reset}};
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    void'(qa[i].pop_front());
                    void'(qb[i].pop_front());
                end
                if (qa[i].size() > 0) begin
                    req_valid[i]          = 1'b1;
                    req_dividend[i*W +: W] = qa[i][0];
                    req_divisor[i*W +: W]  = qb[i][0];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Divider: garbage until DIV_LATENCY cycles after div_start, then the answer held until the next start.
    initial begin
        logic         s;
        logic [W-1:0] a, b, pq, pr;
        logic         ps;
        int           cnt;
        bit           busy;
        div_result    = '0;
        div_remainder = '0;
        div_sign      = 1'b0;
        pq = '0; pr = '0; ps = 1'b0; cnt = 0; busy = 1'b0;
        forever begin
            @(posedge clk);
            s = div_start;
            a = div_dividend;
            b = div_divisor;
            #1;
            if (reset) begin
                busy = 1'b0;
            end else if (s) begin
                golden(a, b, pq, pr, ps);
                cnt  = L - 1;
                busy = 1'b1;
            end else if (busy && cnt > 0) begin
                cnt--;
            end
            if (busy && cnt == 0) begin
                div_result    = pq;
                div_remainder = pr;
                div_sign      = ps;
            end else begin
                div_result    = 16'hDEAD;
                div_remainder = 16'hBEEF;
                div_sign      = ~ps;
            end
        end
    end

    // Cycle model: one op in flight, start at accept+1, response at accept+2+L (accept+1 for local zero).
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        int           win;
        if (reset) begin
            m_pend = 1'b0;
            m_rr   = 0;
            m_free = 0;
        end else begin
            exp_rdy = '0;
            exp_rv  = '0;
            win     = -1;
            if (cyc >= m_free) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (req_valid[(m_rr + k) % N]) win = (m_rr + k) % N;
                end
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            chk("div_start", div_start, (m_pend && !m_zero && cyc == m_start));
            if (m_pend && cyc == m_rsp) exp_rv[m_idx] = 1'b1;
            chk("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv != '0) begin
                chk("rsp_result", rsp_result, m_q);
                chk("rsp_remainder", rsp_remainder, m_r);
                chk("rsp_sign", rsp_sign, m_s);
                chk("rsp_err", rsp_err, m_e);
            end
            if (m_pend && !m_zero && cyc >= m_start && cyc < m_rsp) begin
                chk("div_dividend_hold", div_dividend, m_a);
                chk("div_divisor_hold", div_divisor, m_b);
            end
            if (m_pend && cyc == m_rsp) m_pend = 1'b0;
            if (win >= 0) begin
                m_pend  = 1'b1;
                m_idx   = win;
                m_a     = req_dividend[win*W +: W];
                m_b     = req_divisor[win*W +: W];
`ifdef DIV_ZERO_CHECK_EN
                m_zero  = (m_b == '0);
`else
                m_zero  = 1'b0;
`endif
                m_start = cyc + 1;
                m_rsp   = m_zero ? cyc + 1 : cyc + 2 + L;
                m_free  = m_rsp + 1;
                m_rr    = (win + 1) % N;
                if (m_zero) begin
                    m_q = '1;
                    m_r = m_a;
                    m_s = 1'b0;
                    m_e = 1'b1;
                end else begin
                    golden(m_a, m_b, m_q, m_r, m_s);
                    m_e = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (div_start) start_cnt++;
            if (rsp_valid != '0) begin
                chk("rsp_onehot", $onehot(rsp_valid), 1);
                for (int i = 0; i < N; i++) begin
                    if (rsp_valid[i]) log_q.push_back(i);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int n;
        int sc0;
        int exp_t6 [5];
        exp_t6 = '{1, 2, 3, 0, 1};

        repeat (3) @(negedge clk);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_result", rsp_result, 0);
        chk("reset_rsp_remainder", rsp_remainder, 0);
        chk("reset_rsp_sign", rsp_sign, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_div_dividend", div_dividend, 0);
        chk("reset_div_divisor", div_divisor, 0);
        chk("reset_div_start", div_start, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // All four requesters continuously valid, two ops each.
        log_q.delete();
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) push_op(i, 1000 * (i + 1) + 13 * r, 3 + i + r);
        end
        drain(400);
        chk("rr_count", log_q.size(), 8);
        for (int k = 0; k < 8; k++) chk("rr_order", (k < log_q.size()) ? log_q[k] : -1, k % 4);

        // Single op, literal latency and data.
        @(negedge clk);
        push_op(0, -246, -80);
        @(negedge clk);
        n = 0;
        while (rsp_valid == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("single_latency", n, 18);
        chk("single_index", rsp_valid, 4'b0001);
        chk("single_result", rsp_result, 3);
        chk("single_remainder", rsp_remainder, 6);
        chk("single_sign", rsp_sign, 0);
        chk("single_err", rsp_err, 0);
        drain(100);

        // req2 arrives while req0 is busy.
        log_q.delete();
        @(negedge clk);
        push_op(0, 500, 7);
        @(negedge clk);
        repeat (4) @(negedge clk);
        push_op(2, 77, 5);
        @(negedge clk);
        chk("busy_ready2", req_ready[2], 0);
        chk("busy_dividend", div_dividend, 500);
        drain(100);
        chk("busy_count", log_q.size(), 2);
        chk("busy_first", (log_q.size() > 0) ? log_q[0] : -1, 0);
        chk("busy_second", (log_q.size() > 1) ? log_q[1] : -1, 2);

        // Reset five cycles after div_start aborts the op and resets round-robin.
        log_q.delete();
        @(negedge clk);
        push_op(3, 1234, 10);
        @(negedge clk);
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_req_ready", req_ready, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_result", rsp_result, 0);
        chk("abort_rsp_remainder", rsp_remainder, 0);
        chk("abort_rsp_err", rsp_err, 0);
        chk("abort_div_dividend", div_dividend, 0);
        chk("abort_div_divisor", div_divisor, 0);
        chk("abort_div_start", div_start, 0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (25) @(negedge clk);
        chk("abort_no_rsp", log_q.size(), 0);
        push_op(1, 300, -7);
        push_op(3, -300, 7);
        @(negedge clk);
        chk("rr_reset_grant", req_ready, 4'b0010);
        drain(100);
        chk("after_reset_count", log_q.size(), 2);
        chk("after_reset_first", (log_q.size() > 0) ? log_q[0] : -1, 1);
        chk("after_reset_second", (log_q.size() > 1) ? log_q[1] : -1, 3);

        // Zero divisor.
        sc0 = start_cnt;
        @(negedge clk);
        push_op(0, 100, 0);
        @(negedge clk);
        n = 0;
        while (rsp_valid == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
`ifdef DIV_ZERO_CHECK_EN
        chk("zero_latency", n, 1);
        chk("zero_result", rsp_result, 16'hFFFF);
        chk("zero_remainder", rsp_remainder, 100);
        chk("zero_sign", rsp_sign, 0);
        chk("zero_err", rsp_err, 1);
        drain(100);
        chk("zero_no_start", start_cnt - sc0, 0);
`else
        chk("zero_latency", n, 18);
        chk("zero_err", rsp_err, 0);
        drain(100);
        chk("zero_start", start_cnt - sc0, 1);
`endif

        // Mixed signs and extremes, checked by the cycle model.
        log_q.delete();
        @(negedge clk);
        push_op(1, 1000, 7);
        push_op(1, -1000, 7);
        push_op(2, 32767, -3);
        push_op(3, -32768, 1);
        push_op(0, 5, 9);
        drain(300);
        chk("mixed_count", log_q.size(), 5);
        for (int k = 0; k < 5; k++) chk("mixed_order", (k < log_q.size()) ? log_q[k] : -1, exp_t6[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
